// File: rtl/phys_reg_free_list_if.sv
// Bundles the rename, commit and checkpoint signals of the physical register
// free list. The renamer/commit side uses the master modport and the free list
// uses the slave modport.
interface phys_reg_free_list_if #(
  parameter int NUM_ARCH = 32,
  parameter int NUM_PHYS = 64,
  parameter int ALLOC_W  = 2,
  parameter int FREE_W   = 2,
  parameter int NUM_CKPT = 4
);
  localparam int FL_DEPTH = NUM_PHYS - NUM_ARCH;
  localparam int TAG_W    = $clog2(NUM_PHYS);
  localparam int CNT_W    = $clog2(FL_DEPTH + 1);
  localparam int CK_W     = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;

  logic [ALLOC_W-1:0]             alloc_req;
  logic                           alloc_ok;
  logic [ALLOC_W-1:0][TAG_W-1:0]  alloc_tag;
  logic [FREE_W-1:0]              free_valid;
  logic [FREE_W-1:0][TAG_W-1:0]   free_tag;
  logic                           ckpt_save;
  logic [CK_W-1:0]                ckpt_save_id;
  logic                           ckpt_restore;
  logic [CK_W-1:0]                ckpt_restore_id;
  logic [CNT_W-1:0]               count;
  logic                           empty;
  logic                           overflow_err;

  modport master (
    output alloc_req, free_valid, free_tag,
    output ckpt_save, ckpt_save_id, ckpt_restore, ckpt_restore_id,
    input  alloc_ok, alloc_tag, count, empty, overflow_err
  );

  modport slave (
    input  alloc_req, free_valid, free_tag,
    input  ckpt_save, ckpt_save_id, ckpt_restore, ckpt_restore_id,
    output alloc_ok, alloc_tag, count, empty, overflow_err
  );
endinterface

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags. Rename pops up to ALLOC_W
// tags per cycle from head, commit pushes up to FREE_W tags per cycle at tail,
// and checkpoint slots hold copies of head so a mispredict can rewind head in
// one cycle, reclaiming every tag allocated since the snapshot.
module phys_reg_free_list #(
  parameter int NUM_ARCH = 32,
  parameter int NUM_PHYS = 64,
  parameter int ALLOC_W  = 2,
  parameter int FREE_W   = 2,
  parameter int NUM_CKPT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  phys_reg_free_list_if.slave  fl
);
  localparam int FL_DEPTH = NUM_PHYS - NUM_ARCH;
  localparam int TAG_W    = $clog2(NUM_PHYS);
  localparam int IDX_W    = $clog2(FL_DEPTH);
  localparam int PTR_W    = IDX_W + 1;
  localparam int CNT_W    = $clog2(FL_DEPTH + 1);
  // Wide enough to hold an occupancy plus a full set of frees without wrapping.
  localparam int SUM_W    = PTR_W + 2;

  logic [TAG_W-1:0] fl_mem_r [FL_DEPTH];
  logic [PTR_W-1:0] ckpt_r   [NUM_CKPT];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic             empty_r;
  logic             overflow_r;

  logic [SUM_W-1:0]              n_req_s;
  logic [SUM_W-1:0]              n_free_s;
  logic [SUM_W-1:0]              occ_s;
  logic                          alloc_ok_s;
  logic                          overflow_s;
  logic [ALLOC_W-1:0][TAG_W-1:0] alloc_tag_s;
  logic [PTR_W-1:0]              rd_ofs_s;
  logic [PTR_W-1:0]              rd_ptr_s;
  logic [PTR_W-1:0]              wr_ofs_s;
  logic [PTR_W-1:0]              wr_ptr_s [FREE_W];
  logic [PTR_W-1:0]              head_new_s;
  logic [PTR_W-1:0]              tail_new_s;
  logic [PTR_W-1:0]              diff_s;

  function automatic logic [SUM_W-1:0] popcnt_alloc(input logic [ALLOC_W-1:0] v);
    logic [SUM_W-1:0] n;
    n = '0;
    for (int i = 0; i < ALLOC_W; i++) n = n + SUM_W'(v[i]);
    return n;
  endfunction

  function automatic logic [SUM_W-1:0] popcnt_free(input logic [FREE_W-1:0] v);
    logic [SUM_W-1:0] n;
    n = '0;
    for (int i = 0; i < FREE_W; i++) n = n + SUM_W'(v[i]);
    return n;
  endfunction

  // Allocation grant, lookahead tag read, free compaction and next pointers.
  always_comb begin
    n_req_s     = popcnt_alloc(fl.alloc_req);
    n_free_s    = popcnt_free(fl.free_valid);
    alloc_ok_s  = 1'b0;
    alloc_tag_s = '0;
    rd_ofs_s    = '0;
    rd_ptr_s    = '0;
    wr_ofs_s    = '0;
    head_new_s  = head_r;
    tail_new_s  = tail_r;
    diff_s      = '0;
    occ_s       = '0;
    overflow_s  = 1'b0;

    // A restore discards allocation; otherwise it is all-or-nothing on count.
    if (fl.ckpt_restore) begin
      alloc_ok_s = 1'b0;
    end else if (SUM_W'(count_r) >= n_req_s) begin
      alloc_ok_s = 1'b1;
    end else begin
      alloc_ok_s = 1'b0;
    end

    // The k-th requesting lane reads the k-th entry from head.
    for (int k = 0; k < ALLOC_W; k++) begin
      if (fl.alloc_req[k]) begin
        rd_ptr_s       = head_r + rd_ofs_s;
        alloc_tag_s[k] = fl_mem_r[rd_ptr_s[IDX_W-1:0]];
        rd_ofs_s       = rd_ofs_s + PTR_W'(1);
      end else begin
        alloc_tag_s[k] = '0;
      end
    end

    // Valid free lanes land at consecutive slots from tail, in lane order.
    for (int j = 0; j < FREE_W; j++) begin
      wr_ptr_s[j] = tail_r + wr_ofs_s;
      if (fl.free_valid[j]) begin
        wr_ofs_s = wr_ofs_s + PTR_W'(1);
      end else begin
        wr_ofs_s = wr_ofs_s;
      end
    end

    if (fl.ckpt_restore) begin
      head_new_s = ckpt_r[fl.ckpt_restore_id];
    end else if (alloc_ok_s) begin
      head_new_s = head_r + PTR_W'(n_req_s);
    end else begin
      head_new_s = head_r;
    end

    // Occupancy is measured against the head that will actually be in force,
    // so frees arriving with a restore are judged against the rewound list.
    diff_s     = tail_r - head_new_s;
    occ_s      = SUM_W'(diff_s) + n_free_s;
    overflow_s = (occ_s > SUM_W'(FL_DEPTH));

    if (overflow_s) begin
      tail_new_s = tail_r;
    end else begin
      tail_new_s = tail_r + PTR_W'(n_free_s);
    end
  end

  // Pointer, count, status and checkpoint state.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r     <= '0;
      tail_r     <= PTR_W'(FL_DEPTH);
      count_r    <= CNT_W'(FL_DEPTH);
      empty_r    <= 1'b0;
      overflow_r <= 1'b0;
      for (int c = 0; c < NUM_CKPT; c++) ckpt_r[c] <= '0;
    end else begin
      head_r     <= head_new_s;
      tail_r     <= tail_new_s;
      count_r    <= CNT_W'(tail_new_s - head_new_s);
      empty_r    <= (tail_new_s == head_new_s);
      overflow_r <= overflow_r | overflow_s;
      if (fl.ckpt_save) begin
        ckpt_r[fl.ckpt_save_id] <= head_new_s;
      end else begin
        ckpt_r[fl.ckpt_save_id] <= ckpt_r[fl.ckpt_save_id];
      end
    end
  end

  // Tag storage: preloaded with the non-architectural tags, written by frees.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FL_DEPTH; i++) fl_mem_r[i] <= TAG_W'(NUM_ARCH + i);
    end else begin
      for (int j = 0; j < FREE_W; j++) begin
        if (fl.free_valid[j] && !overflow_s) begin
          fl_mem_r[wr_ptr_s[j][IDX_W-1:0]] <= fl.free_tag[j];
        end
      end
    end
  end

  assign fl.alloc_ok     = alloc_ok_s;
  assign fl.alloc_tag    = alloc_tag_s;
  assign fl.count        = count_r;
  assign fl.empty        = empty_r;
  assign fl.overflow_err = overflow_r;
endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list: allocation lanes, exhaustion,
// wrap-around of freed tags, checkpoint save/restore and sticky overflow.
module tb_phys_reg_free_list;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  phys_reg_free_list_if #(.NUM_ARCH(32), .NUM_PHYS(64), .ALLOC_W(2), .FREE_W(2), .NUM_CKPT(4)) fl ();

  phys_reg_free_list #(.NUM_ARCH(32), .NUM_PHYS(64), .ALLOC_W(2), .FREE_W(2), .NUM_CKPT(4)) dut (
    .clk (clk),
    .rst (rst),
    .fl  (fl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("%s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fl.alloc_req       = 2'b00;
    fl.free_valid      = 2'b00;
    fl.free_tag        = '0;
    fl.ckpt_save       = 1'b0;
    fl.ckpt_save_id    = 2'd0;
    fl.ckpt_restore    = 1'b0;
    fl.ckpt_restore_id = 2'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fl.alloc_req = 2'b11;   // reset must win over a concurrent request
    tick();
    tick();
    rst = 1'b0;
    idle();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    idle();

    // Reset state and a two-lane allocation.
    do_reset();
    chk("rst_count", 32'(fl.count), 32'd32);
    chk("rst_empty", 32'(fl.empty), 32'd0);
    chk("rst_ovf", 32'(fl.overflow_err), 32'd0);
    fl.alloc_req = 2'b11;
    #1;
    chk("a11_ok", 32'(fl.alloc_ok), 32'd1);
    chk("a11_tag0", 32'(fl.alloc_tag[0]), 32'd32);
    chk("a11_tag1", 32'(fl.alloc_tag[1]), 32'd33);
    tick();
    idle();
    chk("a11_count", 32'(fl.count), 32'd30);

    // Single upper lane, then exhaustion.
    do_reset();
    fl.alloc_req = 2'b10;
    #1;
    chk("a10_ok", 32'(fl.alloc_ok), 32'd1);
    chk("a10_tag1", 32'(fl.alloc_tag[1]), 32'd32);
    chk("a10_tag0", 32'(fl.alloc_tag[0]), 32'd0);
    tick();
    chk("a10_count", 32'(fl.count), 32'd31);
    fl.alloc_req = 2'b01;
    #1;
    chk("a01_tag0", 32'(fl.alloc_tag[0]), 32'd33);
    tick();
    for (int i = 0; i < 14; i++) begin
      fl.alloc_req = 2'b11;
      tick();
    end
    fl.alloc_req = 2'b01;
    tick();
    chk("one_left_count", 32'(fl.count), 32'd1);
    fl.alloc_req = 2'b11;
    #1;
    chk("short_ok", 32'(fl.alloc_ok), 32'd0);
    tick();
    chk("short_count", 32'(fl.count), 32'd1);
    fl.alloc_req = 2'b01;
    #1;
    chk("last_ok", 32'(fl.alloc_ok), 32'd1);
    chk("last_tag", 32'(fl.alloc_tag[0]), 32'd63);
    tick();
    idle();
    chk("drained_empty", 32'(fl.empty), 32'd1);
    chk("drained_count", 32'(fl.count), 32'd0);

    // Free into an empty list with a same-cycle request, then reuse.
    fl.alloc_req   = 2'b11;
    fl.free_valid  = 2'b11;
    fl.free_tag[0] = 6'd5;
    fl.free_tag[1] = 6'd9;
    #1;
    chk("empty_ok", 32'(fl.alloc_ok), 32'd0);
    tick();
    idle();
    chk("refill_count", 32'(fl.count), 32'd2);
    chk("refill_empty", 32'(fl.empty), 32'd0);
    fl.alloc_req = 2'b11;
    #1;
    chk("wrap_ok", 32'(fl.alloc_ok), 32'd1);
    chk("wrap_tag0", 32'(fl.alloc_tag[0]), 32'd5);
    chk("wrap_tag1", 32'(fl.alloc_tag[1]), 32'd9);
    tick();
    idle();
    chk("wrap_count", 32'(fl.count), 32'd0);

    // Checkpoint save with allocation, then restore with a free.
    do_reset();
    fl.alloc_req    = 2'b11;
    fl.ckpt_save    = 1'b1;
    fl.ckpt_save_id = 2'd2;
    tick();
    idle();
    fl.alloc_req = 2'b11;
    #1;
    chk("ck_tag0", 32'(fl.alloc_tag[0]), 32'd34);
    tick();
    fl.alloc_req = 2'b01;
    #1;
    chk("ck_tag36", 32'(fl.alloc_tag[0]), 32'd36);
    tick();
    idle();
    chk("ck_count", 32'(fl.count), 32'd27);
    fl.alloc_req       = 2'b11;
    fl.ckpt_restore    = 1'b1;
    fl.ckpt_restore_id = 2'd2;
    fl.ckpt_save       = 1'b1;
    fl.ckpt_save_id    = 2'd3;
    fl.free_valid      = 2'b01;
    fl.free_tag[0]     = 6'd7;
    #1;
    chk("rs_ok", 32'(fl.alloc_ok), 32'd0);
    tick();
    idle();
    chk("rs_count", 32'(fl.count), 32'd31);
    fl.alloc_req = 2'b01;
    #1;
    chk("rs_tag0", 32'(fl.alloc_tag[0]), 32'd34);
    tick();
    idle();
    chk("rs_alloc_count", 32'(fl.count), 32'd30);
    // Slot 3 captured the restored head during the combined save/restore.
    fl.ckpt_restore    = 1'b1;
    fl.ckpt_restore_id = 2'd3;
    tick();
    idle();
    chk("rs3_count", 32'(fl.count), 32'd31);
    fl.alloc_req = 2'b01;
    #1;
    chk("rs3_tag0", 32'(fl.alloc_tag[0]), 32'd34);
    tick();
    idle();

    // Overflow from a full list is rejected and sticky until reset.
    do_reset();
    fl.free_valid  = 2'b01;
    fl.free_tag[0] = 6'd40;
    tick();
    idle();
    chk("ovf_set", 32'(fl.overflow_err), 32'd1);
    chk("ovf_count", 32'(fl.count), 32'd32);
    fl.alloc_req = 2'b11;
    #1;
    chk("ovf_tag0", 32'(fl.alloc_tag[0]), 32'd32);
    tick();
    idle();
    chk("ovf_sticky", 32'(fl.overflow_err), 32'd1);
    chk("ovf_after_count", 32'(fl.count), 32'd30);
    do_reset();
    chk("ovf_cleared", 32'(fl.overflow_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
